// File: rtl/ring_token_arbiter.sv
// rtl/ring_token_arbiter.sv - four-way round-robin arbiter with one-hot token ring and hold limit
//
// Shares one downstream resource among four requesters. A rotating one-hot
// priority token marks where the next arbitration scan starts. The token
// advances to the position just past each winner. A hold counter forcibly
// reclaims a grant that stays high for MAX_HOLD cycles without a release.
//
// Parameters:
//   MAX_HOLD  maximum consecutive granted cycles without done (1..255)
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   req      in   4  level-sensitive request lines, bit i = requester i
//   done     in   1  grantee finished; only looked at while a grant is active
//   gnt      out  4  registered one-hot grant, zero when idle
//   gnt_id   out  2  registered binary index of the grant, zero when idle
//   busy     out  1  registered, high exactly when gnt is non-zero
//   timeout  out  1  one-cycle pulse after a hold-limit revocation
//   ptr      out  4  current one-hot priority token
module ring_token_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout,
  output logic [3:0] ptr
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  logic [0:0] r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_id;
  logic       r_busy;
  logic       r_timeout;
  logic [3:0] r_ptr;
  logic [7:0] r_hold;

  logic [1:0] w_ptr_idx;
  logic [7:0] w_req_dbl;
  logic [3:0] w_req_rot;
  logic [1:0] w_offset;
  logic       w_any_req;
  logic [1:0] w_win_idx;
  logic [3:0] w_win_onehot;
  logic       w_owner_req;
  logic       w_hold_expired;
  logic       w_release;
  logic       w_is_timeout;

  // Binary position of the priority token.
  always_comb begin
    w_ptr_idx = 2'd0;
    case (r_ptr)
      4'b0001: w_ptr_idx = 2'd0;
      4'b0010: w_ptr_idx = 2'd1;
      4'b0100: w_ptr_idx = 2'd2;
      4'b1000: w_ptr_idx = 2'd3;
      default: w_ptr_idx = 2'd0;
    endcase
  end

  // Rotate the request vector so the token position lands on bit 0; the
  // first set bit of the rotated vector is then the distance from the token
  // to the winner, and the 2-bit sum wraps 3 back to 0 for free.
  assign w_req_dbl = {req, req};
  assign w_req_rot = w_req_dbl[{1'b0, w_ptr_idx} +: 4];
  assign w_any_req = |req;

  always_comb begin
    w_offset = 2'd0;
    if (w_req_rot[0]) begin
      w_offset = 2'd0;
    end else if (w_req_rot[1]) begin
      w_offset = 2'd1;
    end else if (w_req_rot[2]) begin
      w_offset = 2'd2;
    end else begin
      w_offset = 2'd3;
    end
  end

  assign w_win_idx    = w_ptr_idx + w_offset;
  assign w_win_onehot = 4'b0001 << w_win_idx;

  // Release conditions while granted: grantee done, grantee dropped its
  // request, or the hold limit reached. Only a pure hold-limit release is
  // reported as a timeout.
  assign w_owner_req    = req[r_gnt_id];
  assign w_hold_expired = (r_hold == HOLD_LIMIT);
  assign w_release      = done | ~w_owner_req | w_hold_expired;
  assign w_is_timeout   = w_hold_expired & ~done & w_owner_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 4'b0000;
      r_gnt_id  <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= 4'b0001;
      r_hold    <= 8'd0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state  <= ST_GRANT;
            r_gnt    <= w_win_onehot;
            r_gnt_id <= w_win_idx;
            r_busy   <= 1'b1;
            r_hold   <= 8'd1;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 4'b0000;
            r_gnt_id  <= 2'd0;
            r_busy    <= 1'b0;
            // Token moves to the slot just past the winner.
            r_ptr     <= {r_gnt[2:0], r_gnt[3]};
            r_hold    <= 8'd0;
            r_timeout <= w_is_timeout;
          end else if (r_hold != HOLD_LIMIT) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = r_busy;
  assign timeout = r_timeout;
  assign ptr     = r_ptr;

endmodule

// File: doc/ring_token_arbiter.md
# ring_token_arbiter

Four-way round-robin arbiter that shares one downstream resource among four requesters. Priority is held in a rotating one-hot token ring that advances past each winner, so every requester is served within three grants of asserting its request. A hold-limit counter forcibly reclaims a grant that is held too long. The block sits between the requesting engines and the shared datapath, and its one-hot grant drives the datapath's input mux select.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum consecutive cycles a grant may stay high without `done`. Legal range is 1..255.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  4  request lines. Bit i is requester i. Level-sensitive.
- done  input  1  the current grantee finished its transaction. Sampled only while a grant is active.
- gnt  output  4  one-hot grant. All zero when no grant is active. Registered.
- gnt_id  output  2  binary index of the active grant. Holds 0 when `gnt` is 0. Registered.
- busy  output  1  high exactly when `gnt` is non-zero.
- timeout  output  1  single-cycle pulse when a grant is revoked by the hold limit.
- ptr  output  4  current one-hot priority token, for debug.

## Operation
- Reset values: `gnt`=0000, `gnt_id`=0, `busy`=0, `timeout`=0, `ptr`=0001, hold counter=0, state=IDLE.
- The FSM has two states: IDLE and GRANT.
- IDLE:
  - If `req` is 0000, stay in IDLE and leave `ptr` unchanged.
  - Otherwise, pick the winner as the first set `req` bit, scanning from the bit marked by `ptr` upward with wrap-around (3 wraps to 0).
  - At the next edge: `gnt` = one-hot of the winner, `gnt_id` = its index, hold counter = 1, state = GRANT.
- GRANT: the grant is released at an edge when any of the following is true in the preceding cycle:
  - (a) `done`=1, or
  - (b) `req[gnt_id]`=0, or
  - (c) hold counter = MAX_HOLD.
- Otherwise the hold counter increments, saturating at MAX_HOLD.
- On release:
  - `gnt` becomes 0000 and `gnt_id` becomes 0.
  - State returns to IDLE.
  - `ptr` is rotated left once from the winner's one-hot. Example: winner 3 gives `ptr`=0001.
  - The hold counter clears to 0.
- `timeout` is 1 in the first cycle after a release caused by (c) alone. If (a) or (b) is also true in the same cycle, the release is normal and `timeout`=0.
- `done` is ignored in IDLE.
- Changes on `req` bits other than the grantee's have no effect while in GRANT.
- No preemption: a higher-priority request never interrupts an active grant.
- `gnt` is always zero or one-hot. `ptr` is always one-hot.

## Timing
- Request-to-grant latency: 1 cycle. A `req` sampled at edge k in IDLE gives `gnt` high from edge k+1.
- Release latency: `done` high before edge k drops `gnt` at edge k.
- Minimum gap between consecutive grants is exactly one cycle with `gnt`=0000, the IDLE arbitration cycle. Back-to-back grants to different requesters are therefore 1 cycle apart.
- Maximum grant length is MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts one cycle and releases with `timeout`=1 unless `done` or a dropped `req` coincides.
- Reset mid-grant: at the reset edge, `gnt` goes to 0000, `ptr` to 0001, counter to 0 and state to IDLE. `timeout` is not pulsed.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then `req`=0001 with `done` pulsed at cycle 3 → `gnt`=0001 from cycle 1, 0000 in cycle 4, `ptr`=0010.
- `req`=1111 held, `done` pulsed each grant → `gnt` sequence 0001, 0010, 0100, 1000, 0001, with one-cycle 0000 gaps between grants.
- `ptr`=0100 and `req`=0011 → winner is 0 (wrap-around), `gnt_id`=0, then `ptr`=0010.
- MAX_HOLD=4, `req`=0010 held, no `done` → `gnt`=0010 for exactly 4 cycles, then `timeout`=1 for 1 cycle, then re-grant to 1 after the gap (`ptr`=0100, no other requester).
- MAX_HOLD=4 with `done`=1 in the 4th granted cycle → release with `timeout`=0.
- `rst` asserted during the 3rd granted cycle with `req`=1000 → next cycle `gnt`=0000, `ptr`=0001, `busy`=0, and re-grant to 3 one cycle after `rst` deasserts.
